fp_square: RTL and testbench
============================

Name: fp_square

Overview:
- Iterative IEEE-754 single-precision squarer, the inverse of the sqrt unit. Computes Out = A*A.
- Used to check and refine sqrt results by squaring them back, and as a standalone FP op on the integer-domain clock.
- Start/done handshake; one mantissa bit per cycle via shift-add.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width. The hidden-1 mantissa is MANT_W+1 bits.
- BIAS, 127, exponent bias. Equals 2^(EXP_W-1)-1.

Ports:
- int_clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request. Sampled only in IDLE.
- A  input  32  operand {sign, exp, frac}.
- Out  output  32  result. Holds until the next result is written.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when Out is updated.

Behaviour:
- Reset (async, any state): state=IDLE, Out=0, busy=0, done=0, partial product discarded.
- States: IDLE, UNPACK, MULT, NORM, ROUND, FIN.
- IDLE:
  - If start=1 at edge 0, latch A, busy=1, go to UNPACK.
  - start while busy is ignored. A is not resampled.
- UNPACK (1 cycle), classify the latched operand:
  - exp=0: zero; denormals are flushed to zero.
  - exp=all-ones, frac=0: Inf.
  - exp=all-ones, frac≠0: NaN.
  - Specials go straight to FIN with Out: zero→0x00000000, Inf→0x7F800000, NaN→canonical 0x7FC00000.
  - Normal operand: m={1,frac}, e=2*exp-BIAS (10-bit signed), go to MULT.
- MULT (MANT_W+1 = 24 cycles):
  - Shift-add. Each cycle, if the multiplier LSB=1, add the multiplicand to the 48-bit accumulator; then shift.
  - Counter 0..23, exit at 23.
- NORM (1 cycle):
  - If P[47]=1, take the mantissa from P[46:24], e+=1.
  - Otherwise take it from P[45:23].
  - Guard = next lower bit; sticky = OR of the remaining bits.
- ROUND (1 cycle):
  - Round-to-nearest-even: increment if guard & (sticky | lsb).
  - Fraction carry-out sets frac=0 and e+=1.
  - Then e>=255 → Out=0x7F800000; e<=0 → Out=0x00000000 (flush).
- FIN: write Out (sign always 0; -0 squared gives +0), done=1 for one cycle, busy=0, go to IDLE.
- Latency from the start edge to the done edge:
  - Normal operands: 28 cycles (UNPACK 1 + MULT 24 + NORM 1 + ROUND 1 + FIN 1).
  - Specials: 2 cycles.
- start high in the FIN cycle is ignored; a new start is accepted from IDLE onward.
- A may change freely after acceptance.

Decomposition:
- Package fp_pkg holds:
  - EXP_W, MANT_W, BIAS.
  - Constants POS_INF=0x7F800000, QNAN=0x7FC00000, POS_ZERO=0.
  - Enum fsq_state_t.
  - Helper functions is_nan, is_inf, is_zero (shared with sqrt and the add/mul units).
- One sub-module: seq_mant_mult, a 24x24→48 iterative shift-add multiplier.
  - Interface: load, operand a, operand b, busy, done, product P.
  - fp_square keeps the classify/normalize/round FSM.

Test Plan:
- 0x3F800000 (1.0), start pulse → after 28 cycles done=1, Out=0x3F800000; busy high for exactly 28 cycles.
- 0x40000000 (2.0) → 0x40800000. 0x42C80000 (100.0) → 0x461C4000. 0xC0400000 (-3.0) → 0x41100000.
- Special operands:
  - 0x00000000 → 0x00000000.
  - 0x80000001 (negative denormal) → 0x00000000.
  - 0x7F800000 → 0x7F800000.
  - 0x7FC00001 → 0x7FC00000.
  - Each with done 2 cycles after start.
- Range limits:
  - 0x7F000000 (2^127) → 0x7F800000 (overflow).
  - 0x1F800000 (2^-64) → 0x00000000 (underflow).
  - 0x3F800001 → 0x3F800002 (round-nearest).
- Handshake:
  - start re-asserted at cycle 10 of an operation → ignored, only one done.
  - reset asserted at cycle 15 → Out=0, busy=0 immediately (async).
  - Next start with 0x40000000 completes normally to 0x40800000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state type and operand classifiers
// used by the iterative FP units (square, sqrt, add, mul).
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;

  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_FIN
  } fsq_state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[MANT_W+EXP_W-1:MANT_W]) && (|x[MANT_W-1:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[MANT_W+EXP_W-1:MANT_W]) && !(|x[MANT_W-1:0]);
  endfunction

  // Denormals count as zero: these units flush them on input.
  function automatic logic is_zero(input logic [31:0] x);
    return !(|x[MANT_W+EXP_W-1:MANT_W]);
  endfunction
endpackage

// File: rtl/seq_mant_mult.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// o_done flags the cycle whose edge performs the final accumulate.
module seq_mant_mult
  import fp_pkg::*;
#(
  parameter int W = SIG_W
) (
  input  logic           int_clk,
  input  logic           reset,
  input  logic           i_load,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_p
);
  localparam int CNT_W = $clog2(W);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic           r_busy;
  logic           w_last;

  assign w_last = r_busy && (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_p    = r_acc;
endmodule

// File: rtl/fp_square.sv
// Iterative IEEE-754 single-precision squarer (Out = A*A), round-to-nearest-even,
// denormals flushed to zero. Result sign is always positive.
//
// state  | meaning
// IDLE   | waiting for start, operand latched on acceptance
// UNPACK | classify operand; specials jump to FIN, normals launch the multiplier
// MULT   | 24-cycle shift-add of the hidden-1 significand with itself
// NORM   | pick mantissa window from the 48-bit product, derive guard/sticky
// ROUND  | RNE increment, carry into exponent, overflow/underflow clamp
// FIN    | publish Out, pulse done, drop busy
module fp_square
  import fp_pkg::*;
(
  input  logic        int_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  output logic [31:0] Out,
  output logic        busy,
  output logic        done
);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] L_BIAS    = XW'(BIAS);
  localparam logic signed [XW-1:0] L_ONE     = XW'(1);
  localparam logic signed [XW-1:0] L_ZERO    = XW'(0);
  localparam logic signed [XW-1:0] L_EXP_MAX = XW'((1 << EXP_W) - 1);

  fsq_state_t              r_state;
  logic [31:0]             r_a;
  logic signed [XW-1:0]    r_exp;
  logic [MANT_W-1:0]       r_mant;
  logic                    r_guard;
  logic                    r_sticky;
  logic [31:0]             r_res;
  logic [31:0]             r_out;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_special;
  logic                    w_mult_load;
  logic                    w_mult_busy;
  logic                    w_mult_done;
  logic [SIG_W-1:0]        w_sig;
  logic [PROD_W-1:0]       w_p;
  logic                    w_inc;
  logic [MANT_W:0]         w_rnd;
  logic signed [XW-1:0]    w_exp_r;

  assign w_special   = is_zero(r_a) || is_nan(r_a) || is_inf(r_a);
  assign w_mult_load = (r_state == S_UNPACK) && !w_special;
  assign w_sig       = {1'b1, r_a[MANT_W-1:0]};

  seq_mant_mult #(.W(SIG_W)) u_mult (
    .int_clk (int_clk),
    .reset   (reset),
    .i_load  (w_mult_load),
    .i_a     (w_sig),
    .i_b     (w_sig),
    .o_busy  (w_mult_busy),
    .o_done  (w_mult_done),
    .o_p     (w_p)
  );

  // A fraction carry-out leaves w_rnd[MANT_W-1:0] at zero, so only the exponent moves.
  assign w_inc   = r_guard && (r_sticky || r_mant[0]);
  assign w_rnd   = {1'b0, r_mant} + {{MANT_W{1'b0}}, w_inc};
  assign w_exp_r = r_exp + (w_rnd[MANT_W] ? L_ONE : L_ZERO);

  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_res    <= POS_ZERO;
      r_out    <= POS_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_busy  <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (is_zero(r_a)) begin
            r_res   <= POS_ZERO;
            r_state <= S_FIN;
          end else if (is_nan(r_a)) begin
            r_res   <= QNAN;
            r_state <= S_FIN;
          end else if (is_inf(r_a)) begin
            r_res   <= POS_INF;
            r_state <= S_FIN;
          end else begin
            r_exp   <= $signed({1'b0, r_a[MANT_W+EXP_W-1:MANT_W], 1'b0}) - L_BIAS;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          if (w_mult_done || !w_mult_busy) r_state <= S_NORM;
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4): top bit decides the window.
          if (w_p[PROD_W-1]) begin
            r_mant   <= w_p[PROD_W-2 -: MANT_W];
            r_guard  <= w_p[PROD_W-2-MANT_W];
            r_sticky <= |w_p[PROD_W-3-MANT_W:0];
            r_exp    <= r_exp + L_ONE;
          end else begin
            r_mant   <= w_p[PROD_W-3 -: MANT_W];
            r_guard  <= w_p[PROD_W-3-MANT_W];
            r_sticky <= |w_p[PROD_W-4-MANT_W:0];
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (w_exp_r >= L_EXP_MAX) r_res <= POS_INF;
          else if (w_exp_r <= L_ZERO) r_res <= POS_ZERO;
          else r_res <= {1'b0, w_exp_r[EXP_W-1:0], w_rnd[MANT_W-1:0]};
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_out   <= r_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out  = r_out;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_fp_square.sv
// Self-checking bench for fp_square: directed corner cases, random operands
// against an arithmetic reference model, and start/reset handshake scenarios.
module tb_fp_square;
  logic        int_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] A       = '0;
  logic [31:0] Out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 int_clk = ~int_clk;

  fp_square dut (
    .int_clk (int_clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .Out     (Out),
    .busy    (busy),
    .done    (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Value-level model: square the 24-bit significand exactly, then round the
  // integer product to 24 significant bits with ties-to-even.
  function automatic logic [31:0] ref_square(input logic [31:0] a);
    int          ex;
    int          e;
    int          sh;
    logic [63:0] m;
    logic [63:0] p;
    logic [63:0] keep;
    logic [63:0] rem;
    logic [63:0] half;
    ex = int'(a[30:23]);
    if (ex == 0) return 32'h0000_0000;
    if (ex == 255) return (a[22:0] == 23'd0) ? 32'h7F80_0000 : 32'h7FC0_0000;
    m  = 64'h80_0000 + {41'd0, a[22:0]};
    p  = m * m;
    e  = 2 * ex - 127;
    sh = 23;
    if (p >= 64'h8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
    if (keep == 64'h100_0000) begin
      keep = 64'h80_0000;
      e    = e + 1;
    end
    if (e >= 255) return 32'h7F80_0000;
    if (e <= 0) return 32'h0000_0000;
    return {1'b0, e[7:0], keep[22:0]};
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    return (a[30:23] == 8'h00 || a[30:23] == 8'hFF) ? 2 : 28;
  endfunction

  task automatic run_op(input logic [31:0] a, input string tag);
    int          cyc;
    int          busy_cyc;
    int          exp_lat;
    logic [31:0] exp_out;
    exp_out = ref_square(a);
    exp_lat = lat_of(a);
    @(negedge int_clk);
    A     = a;
    start = 1'b1;
    @(posedge int_clk);
    #1;
    start    = 1'b0;
    A        = $urandom;
    cyc      = 0;
    busy_cyc = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge int_clk);
      #1;
      cyc++;
      if (busy) busy_cyc++;
    end
    check_val($sformatf("%s_lat", tag), cyc, exp_lat);
    check_val($sformatf("%s_out", tag), Out, exp_out);
    check_val($sformatf("%s_busy", tag), busy_cyc, exp_lat);
    @(posedge int_clk);
    #1;
    check_val($sformatf("%s_pulse", tag), {31'd0, done}, 32'd0);
    check_val($sformatf("%s_hold", tag), Out, exp_out);
  endtask

  logic [31:0] dir_ops [14] = '{
    32'h3F80_0000, 32'h4000_0000, 32'h42C8_0000, 32'hC040_0000,
    32'h0000_0000, 32'h8000_0001, 32'h7F80_0000, 32'h7FC0_0001,
    32'h7F00_0000, 32'h1F80_0000, 32'h3F80_0001, 32'hFF80_0000,
    32'h3FFF_FFFF, 32'h5F80_0000
  };

  initial begin
    int          dones;
    int          done_cyc;
    logic [31:0] r;

    repeat (3) @(posedge int_clk);
    #1;
    check_val("rst_out", Out, 32'h0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    @(negedge int_clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_op(dir_ops[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      if (i % 3 != 0) r[30:23] = 8'($urandom_range(190, 64));
      run_op(r, $sformatf("rnd%0d", i));
    end

    // start re-asserted mid-operation must be ignored
    @(negedge int_clk);
    A     = 32'h4040_0000;
    start = 1'b1;
    @(posedge int_clk);
    #1;
    start    = 1'b0;
    A        = $urandom;
    dones    = 0;
    done_cyc = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge int_clk);
      start = (c == 10);
      if (c == 10) A = 32'h3F80_0000;
      @(posedge int_clk);
      #1;
      if (done) begin
        dones++;
        done_cyc = c;
      end
    end
    start = 1'b0;
    check_val("ign_dones", dones, 32'd1);
    check_val("ign_lat", done_cyc, 32'd28);
    check_val("ign_out", Out, 32'h4110_0000);

    // async reset mid-operation
    @(negedge int_clk);
    A     = 32'h42C8_0000;
    start = 1'b1;
    @(posedge int_clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge int_clk);
    @(negedge int_clk);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_out", Out, 32'h0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_done", {31'd0, done}, 32'd0);
    @(posedge int_clk);
    @(negedge int_clk);
    reset = 1'b0;
    run_op(32'h4000_0000, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
